// File: rtl/fru_windowed_filter_unit.sv
// fru_windowed_filter_unit
// ------------------------------------------------------------------
// Windowed per-bit signal filter. It sits between the patch trigger
// logic and the controlled SoC signals. Each bit has a 2-bit mode:
//   00 pass, 01 force-constant, 10 hold, 11 sticky-OR.
// The mode applies only while the unit is in its ACTIVE window.
//
// Configuration is written per bit into shadow registers. A commit
// pulse then copies the shadow set into the active set in one step.
// A commit that arrives during ACTIVE is deferred to the edge that
// leaves ACTIVE, so a running window always sees one stable config.
//
// Optional feature (macro FRU_FILTER_OVERRIDE_CNT_EN): adds the
// override_cnt output. It counts ACTIVE cycles in which q_out != q_in.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   q_in / q_out   controllable inputs / filtered outputs (combinational)
//   arm            IDLE -> ARMED request; win_len is latched here
//   trigger        ARMED -> ACTIVE
//   disarm         abort to IDLE from any state (highest priority)
//   win_len        window length in cycles, 0 = unbounded
//   cfg_valid/cfg_ready/cfg_idx/cfg_mode/cfg_const
//                  per-bit shadow config write handshake
//   cfg_commit     shadow -> active config copy request
//   active         high during ACTIVE cycles
//   override_cnt   (optional) saturating count of overriding cycles
// ------------------------------------------------------------------
module fru_windowed_filter_unit #(
  parameter  int FILTER_SIZE = 10,
  parameter  int CNT_W       = 16,
  localparam int IDX_W       = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FILTER_SIZE-1:0] q_in,
  output logic [FILTER_SIZE-1:0] q_out,
  input  logic                   trigger,
  input  logic                   arm,
  input  logic                   disarm,
  input  logic [CNT_W-1:0]       win_len,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [1:0]             cfg_mode,
  input  logic                   cfg_const,
  input  logic                   cfg_commit,
`ifdef FRU_FILTER_OVERRIDE_CNT_EN
  output logic [CNT_W-1:0]       override_cnt,
`endif
  output logic                   active
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_FORCE  = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;
  localparam logic [1:0] MODE_STICKY = 2'b11;

  state_t                        state_r;
  state_t                        state_nxt_s;

  logic [FILTER_SIZE-1:0][1:0]   shadow_mode_r;
  logic [FILTER_SIZE-1:0]        shadow_const_r;
  logic [FILTER_SIZE-1:0][1:0]   shadow_mode_nxt_s;
  logic [FILTER_SIZE-1:0]        shadow_const_nxt_s;
  logic [FILTER_SIZE-1:0][1:0]   act_mode_r;
  logic [FILTER_SIZE-1:0]        act_const_r;

  logic [FILTER_SIZE-1:0]        hold_r;
  logic [FILTER_SIZE-1:0]        sticky_r;
  logic [CNT_W-1:0]              win_len_r;
  logic [CNT_W-1:0]              cnt_r;
  logic                          pending_commit_r;
  logic                          pending_nxt_s;

  logic                          latch_len_s;
  logic                          enter_act_s;
  logic                          leave_act_s;
  logic                          copy_cfg_s;
  logic                          cfg_wr_s;
  logic                          bounded_s;
  logic [31:0]                   idx_ext_s;
  logic [FILTER_SIZE-1:0]        q_filt_s;

  assign bounded_s = (win_len_r != {CNT_W{1'b0}});
  assign cfg_wr_s  = cfg_valid & ~pending_commit_r;
  assign idx_ext_s = 32'(cfg_idx);
  assign cfg_ready = ~pending_commit_r;
  assign active    = (state_r == ST_ACTIVE);
  assign q_out     = q_filt_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and control strobes; disarm dominates arm/trigger
  always_comb begin
    state_nxt_s = state_r;
    latch_len_s = 1'b0;
    enter_act_s = 1'b0;
    leave_act_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (disarm) begin
          state_nxt_s = ST_IDLE;
        end else if (arm) begin
          state_nxt_s = ST_ARMED;
          latch_len_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          state_nxt_s = ST_IDLE;
        end else if (trigger) begin
          state_nxt_s = ST_ACTIVE;
          enter_act_s = 1'b1;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_ACTIVE: begin
        if (disarm) begin
          state_nxt_s = ST_IDLE;
          leave_act_s = 1'b1;
        end else if (bounded_s && (cnt_r == CNT_W'(1))) begin
          state_nxt_s = ST_IDLE;
          leave_act_s = 1'b1;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Shadow config next value; out-of-range indices match no bit and are dropped
  always_comb begin
    shadow_mode_nxt_s  = shadow_mode_r;
    shadow_const_nxt_s = shadow_const_r;
    for (int i = 0; i < FILTER_SIZE; i++) begin
      if (cfg_wr_s && (idx_ext_s == 32'(i))) begin
        shadow_mode_nxt_s[i]  = cfg_mode;
        shadow_const_nxt_s[i] = cfg_const;
      end else begin
        shadow_mode_nxt_s[i]  = shadow_mode_r[i];
        shadow_const_nxt_s[i] = shadow_const_r[i];
      end
    end
  end

  // Commit control: immediate outside ACTIVE, deferred to the leaving edge inside it
  always_comb begin
    copy_cfg_s    = 1'b0;
    pending_nxt_s = pending_commit_r;
    if (state_r == ST_ACTIVE) begin
      if (leave_act_s) begin
        copy_cfg_s    = pending_commit_r | cfg_commit;
        pending_nxt_s = 1'b0;
      end else if (cfg_commit) begin
        pending_nxt_s = 1'b1;
      end else begin
        pending_nxt_s = pending_commit_r;
      end
    end else begin
      copy_cfg_s    = cfg_commit;
      pending_nxt_s = 1'b0;
    end
  end

  // Shadow/active configuration and pending-commit registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_mode_r    <= {FILTER_SIZE{2'b00}};
      shadow_const_r   <= {FILTER_SIZE{1'b0}};
      act_mode_r       <= {FILTER_SIZE{2'b00}};
      act_const_r      <= {FILTER_SIZE{1'b0}};
      pending_commit_r <= 1'b0;
    end else begin
      shadow_mode_r    <= shadow_mode_nxt_s;
      shadow_const_r   <= shadow_const_nxt_s;
      pending_commit_r <= pending_nxt_s;
      // the copy takes the post-write shadow so a same-cycle write is included
      if (copy_cfg_s) begin
        act_mode_r  <= shadow_mode_nxt_s;
        act_const_r <= shadow_const_nxt_s;
      end else begin
        act_mode_r  <= act_mode_r;
        act_const_r <= act_const_r;
      end
    end
  end

  // Window length latch and countdown
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_len_r <= {CNT_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      if (latch_len_s) begin
        win_len_r <= win_len;
      end else begin
        win_len_r <= win_len_r;
      end
      if (enter_act_s) begin
        cnt_r <= win_len_r;
      end else if ((state_r == ST_ACTIVE) && bounded_s) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Hold snapshot at the trigger edge; sticky accumulation during ACTIVE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_r   <= {FILTER_SIZE{1'b0}};
      sticky_r <= {FILTER_SIZE{1'b0}};
    end else begin
      if (enter_act_s) begin
        hold_r   <= q_in;
        sticky_r <= {FILTER_SIZE{1'b0}};
      end else if (state_r == ST_ACTIVE) begin
        hold_r   <= hold_r;
        sticky_r <= sticky_r | q_in;
      end else begin
        hold_r   <= hold_r;
        sticky_r <= sticky_r;
      end
    end
  end

  // Per-bit output select; pure pass-through outside ACTIVE
  always_comb begin
    q_filt_s = q_in;
    for (int i = 0; i < FILTER_SIZE; i++) begin
      if (state_r == ST_ACTIVE) begin
        case (act_mode_r[i])
          MODE_PASS:   q_filt_s[i] = q_in[i];
          MODE_FORCE:  q_filt_s[i] = act_const_r[i];
          MODE_HOLD:   q_filt_s[i] = hold_r[i];
          MODE_STICKY: q_filt_s[i] = q_in[i] | sticky_r[i];
          default:     q_filt_s[i] = q_in[i];
        endcase
      end else begin
        q_filt_s[i] = q_in[i];
      end
    end
  end

`ifdef FRU_FILTER_OVERRIDE_CNT_EN
  logic [CNT_W-1:0] ovr_cnt_r;
  assign override_cnt = ovr_cnt_r;

  // Saturating count of ACTIVE cycles in which the filter changed any bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovr_cnt_r <= {CNT_W{1'b0}};
    end else if (enter_act_s) begin
      ovr_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ACTIVE) && (q_filt_s != q_in) &&
                 (ovr_cnt_r != {CNT_W{1'b1}})) begin
      ovr_cnt_r <= ovr_cnt_r + CNT_W'(1);
    end else begin
      ovr_cnt_r <= ovr_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_fru_windowed_filter_unit.sv
// Self-checking bench for fru_windowed_filter_unit: directed scenarios
// followed by randomized traffic, all checked against a cycle-level
// behavioural model held in plain arrays and integers.
module tb_fru_windowed_filter_unit;
  localparam int N  = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  q_in;
  logic [N-1:0]  q_out;
  logic          trigger, arm, disarm;
  logic [CW-1:0] win_len;
  logic          cfg_valid, cfg_ready;
  logic [3:0]    cfg_idx;
  logic [1:0]    cfg_mode;
  logic          cfg_const, cfg_commit;
  logic          active;
`ifdef FRU_FILTER_OVERRIDE_CNT_EN
  logic [CW-1:0] override_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fru_windowed_filter_unit #(.FILTER_SIZE(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .q_out(q_out),
    .trigger(trigger), .arm(arm), .disarm(disarm), .win_len(win_len),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_mode(cfg_mode), .cfg_const(cfg_const), .cfg_commit(cfg_commit),
`ifdef FRU_FILTER_OVERRIDE_CNT_EN
    .override_cnt(override_cnt),
`endif
    .active(active)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [1:0] m_smode [N];
  bit       m_sconst[N];
  bit [1:0] m_amode [N];
  bit       m_aconst[N];
  bit       m_hold  [N];
  bit       m_stk   [N];
  bit       m_armed, m_win, m_pend;
  int       m_len, m_left, m_ovr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_smode[i] = 2'd0; m_sconst[i] = 1'b0; m_amode[i] = 2'd0; m_aconst[i] = 1'b0;
      m_hold[i] = 1'b0; m_stk[i] = 1'b0;
    end
    m_armed = 1'b0; m_win = 1'b0; m_pend = 1'b0;
    m_len = 0; m_left = 0; m_ovr = 0;
  endtask

  function automatic logic [N-1:0] model_q(input logic [N-1:0] q);
    logic [N-1:0] r;
    r = q;
    if (m_win) begin
      for (int i = 0; i < N; i++) begin
        case (m_amode[i])
          2'd1:    r[i] = m_aconst[i];
          2'd2:    r[i] = m_hold[i];
          2'd3:    r[i] = q[i] | m_stk[i];
          default: r[i] = q[i];
        endcase
      end
    end
    return r;
  endfunction

  task automatic model_copy();
    for (int i = 0; i < N; i++) begin
      m_amode[i] = m_smode[i];
      m_aconst[i] = m_sconst[i];
    end
  endtask

  // what the design must do at one rising edge, given the current inputs
  task automatic model_edge();
    logic [N-1:0] qo;
    bit was_win, leave, enter;
    if (!rst_n) begin
      model_reset();
      return;
    end
    qo = model_q(q_in);
    was_win = m_win; leave = 1'b0; enter = 1'b0;
    if (cfg_valid && !m_pend && int'(cfg_idx) < N) begin
      m_smode[cfg_idx] = cfg_mode;
      m_sconst[cfg_idx] = cfg_const;
    end
    if (m_win && qo != q_in && m_ovr < 65535) m_ovr++;
    if (m_win) for (int i = 0; i < N; i++) if (q_in[i]) m_stk[i] = 1'b1;
    if (disarm) begin
      leave = m_win; m_win = 1'b0; m_armed = 1'b0;
    end else if (m_win) begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_win = 1'b0; leave = 1'b1; end
      end
    end else if (m_armed) begin
      if (trigger) begin m_armed = 1'b0; m_win = 1'b1; m_left = m_len; enter = 1'b1; end
    end else if (arm) begin
      m_armed = 1'b1; m_len = int'(win_len);
    end
    if (enter) begin
      for (int i = 0; i < N; i++) begin m_hold[i] = q_in[i]; m_stk[i] = 1'b0; end
      m_ovr = 0;
    end
    if (!was_win) begin
      if (cfg_commit) model_copy();
    end else if (leave) begin
      if (cfg_commit || m_pend) model_copy();
      m_pend = 1'b0;
    end else if (cfg_commit) begin
      m_pend = 1'b1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic sample();
    @(negedge clk);
    chk("q_out", 32'(q_out), 32'(model_q(q_in)));
    chk("active", 32'(active), 32'(m_win));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
`ifdef FRU_FILTER_OVERRIDE_CNT_EN
    chk("override_cnt", 32'(override_cnt), 32'(m_ovr));
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic quiet();
    arm = 1'b0; trigger = 1'b0; disarm = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [1:0] mode, input logic c);
    cfg_valid = 1'b1; cfg_idx = 4'(idx); cfg_mode = mode; cfg_const = c;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
  endtask

  task automatic arm_len(input int len);
    arm = 1'b1; win_len = CW'(len); tick(); arm = 1'b0;
  endtask

  task automatic fire();
    trigger = 1'b1; tick(); trigger = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; quiet(); win_len = '0; cfg_idx = '0; cfg_mode = '0; cfg_const = 1'b0;
    q_in = 10'h155;
    model_reset();
    advance(); advance();
    sample();
    rst_n = 1'b1;
    advance();

    // reset state and default-config window
    sample();
    chk("rst_q_out", 32'(q_out), 32'h155);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    advance();
    arm_len(3); fire();
    for (int i = 0; i < 3; i++) begin
      sample(); chk("dflt_q_out", 32'(q_out), 32'h155); advance();
    end
    tick();

    // force bits 3 and 0, window of 4
    wr(3, 2'b01, 1'b1); wr(0, 2'b01, 1'b0); commit();
    arm_len(4);
    q_in = 10'h001; fire();
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("force_q_out", 32'(q_out), (i < 4) ? 32'h008 : 32'h001);
      chk("force_active", 32'(active), (i < 4) ? 32'd1 : 32'd0);
      advance();
    end
`ifdef FRU_FILTER_OVERRIDE_CNT_EN
    sample(); chk("ovr_cnt_4", 32'(override_cnt), 32'd4); advance();
`endif

    // hold on bit 5, sticky on bit 7
    wr(5, 2'b10, 1'b0); wr(7, 2'b11, 1'b0); commit();
    arm_len(6);
    q_in = 10'h020; fire();
    for (int i = 0; i < 8; i++) begin
      q_in = (i == 2) ? 10'h080 : 10'h000;
      sample();
      if (i < 6) chk("hold_b5", 32'(q_out[5]), 32'd1);
      if (i >= 2 && i < 6) chk("sticky_b7", 32'(q_out[7]), 32'd1);
      advance();
    end

    // unbounded window, ended by disarm
    arm_len(0); fire();
    for (int i = 0; i < 100; i++) begin
      q_in = N'($urandom);
      sample(); chk("unbnd_active", 32'(active), 32'd1); advance();
    end
    disarm = 1'b1; tick(); disarm = 1'b0;
    q_in = 10'h2aa;
    sample();
    chk("disarm_active", 32'(active), 32'd0);
    chk("disarm_pass", 32'(q_out), 32'h2aa);
    advance();

    // commit inside ACTIVE is deferred
    arm_len(5); q_in = 10'h000; fire();
    tick();
    cfg_valid = 1'b1; cfg_idx = 4'd2; cfg_mode = 2'b01; cfg_const = 1'b1; cfg_commit = 1'b1;
    tick();
    quiet();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("pend_ready", 32'(cfg_ready), 32'd0);
      chk("pend_b2", 32'(q_out[2]), 32'(q_in[2]));
      advance();
    end
    sample(); chk("pend_done_ready", 32'(cfg_ready), 32'd1); advance();
    arm_len(2); fire();
    sample(); chk("b2_forced", 32'(q_out[2]), 32'd1); advance();
    tick(); tick();

    // out-of-range index is dropped
    wr(15, 2'b01, 1'b1); commit();

    // arm+trigger together in IDLE only arms
    arm = 1'b1; trigger = 1'b1; win_len = CW'(3); tick(); quiet();
    sample(); chk("armtrig_active", 32'(active), 32'd0); advance();
    q_in = 10'h3ff; fire();
    sample(); chk("armtrig_fire", 32'(active), 32'd1); advance();

    // reset in the middle of a window
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    q_in = 10'h0f0;
    sample();
    chk("midrst_active", 32'(active), 32'd0);
    chk("midrst_pass", 32'(q_out), 32'h0f0);
    advance();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      rst_n      = ($urandom_range(199) != 0);
      arm        = ($urandom_range(9) == 0);
      trigger    = ($urandom_range(4) == 0);
      disarm     = ($urandom_range(39) == 0);
      win_len    = CW'($urandom_range(8));
      cfg_valid  = ($urandom_range(2) == 0);
      cfg_idx    = 4'($urandom_range(15));
      cfg_mode   = 2'($urandom_range(3));
      cfg_const  = 1'($urandom_range(1));
      cfg_commit = ($urandom_range(14) == 0);
      q_in       = N'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
